bit_time_gen: RTL and testbench
===============================

# bit_time_gen

Parametrised bit-timing engine for the UART datapath, generalising the fixed 20-bit bit-time counter. It produces a one-cycle bit-time-up pulse every `k` clocks while enabled. An optional half-bit first interval centres receiver sampling mid-bit. It also counts bits per frame and signals frame completion, so the TX and RX shift FSMs no longer keep their own bit counters.

## Interface
- `CNT_W`, default 20: width of the bit-time divisor and cycle counter.
- `BIT_W`, default 4: width of the frame-length input and the bit index.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately on assertion.
- `k` in CNT_W: clocks per bit, from the baud decoder; sampled only at arm.
- `frame_bits` in BIT_W: ticks per frame (e.g. 10 = start+8 data+stop); sampled only at arm; 0 treated as 1.
- `half_first` in 1: 1 = first interval is half a bit (RX); sampled only at arm.
- `do_it` in 1: level enable; rising into IDLE arms the block; low aborts.
- `btu` out 1: bit-time-up pulse, one cycle wide.
- `bit_idx` out BIT_W: ticks completed so far in the current frame.
- `frame_done` out 1: one-cycle pulse, coincident with the final `btu` of the frame.
- `busy` out 1: high in HALF or RUN.

## Operation
- Latched at arm: `k_q`, `nbits_q`, and the mode.
- Clamps: `k_q = max(k, 2)`; half target `h_q = max(k_q >> 1, 1)`; `nbits_q = max(frame_bits, 1)`.
- FSM states: IDLE, HALF, RUN, DONE. Encoding lives in the package.
- IDLE: `cnt = 0`, `bit_idx = 0`. If `do_it = 1` at an edge, latch the inputs, clear `cnt`, and go to HALF if `half_first = 1`, else RUN.
- HALF: `cnt` increments each edge. `btu = (cnt == h_q - 1)`. On that edge `cnt` clears and the state goes to RUN. The half tick does not increment `bit_idx` and never raises `frame_done`.
- RUN: `btu = (cnt == k_q - 1)`. On a tick `cnt` clears and `bit_idx` increments. `frame_done = btu && (bit_idx == nbits_q - 1)`. On that edge the state goes to DONE and `bit_idx` holds at `nbits_q`.
- DONE: no ticks and `cnt` holds 0. The block stays in DONE until `do_it = 0`, then returns to IDLE. It cannot re-arm without a low cycle on `do_it`.
- `do_it = 0` in HALF or RUN: go to IDLE on the next edge, clear `cnt` and `bit_idx`, and emit no `btu` that cycle. `btu` and `frame_done` are gated by `do_it` (combinational), so the abort cycle never pulses.
- Input changes while armed: changes to `k`, `frame_bits` or `half_first` are ignored until the next arm.
- Counter width: `cnt` is CNT_W bits and never wraps, because it clears at `k_q - 1 <= 2^CNT_W - 2`.
- Output derivation: all outputs decode from registered state, `cnt` and the latched values; there are no combinational input-to-output paths except the `do_it` gate.

## Timing
- Reset values: `btu = 0`, `frame_done = 0`, `busy = 0`, `bit_idx = 0`; state IDLE, `cnt = 0`, latched registers 0.
- Edge numbering: E0 is the first edge with `do_it = 1` in IDLE; `busy` rises after E0.
- RUN mode: the first `btu` is high from E(k_q-1) to E(k_q); subsequent ticks are exactly `k_q` cycles apart.
- HALF mode: the half tick is high from E(h_q-1) to E(h_q); the first data tick follows `k_q` cycles later.
- `frame_done` and `busy`: `frame_done` is high in the same cycle as the `nbits_q`-th RUN tick; `busy` falls after that edge.
- `bit_idx` timing: updates on the edge that ends each `btu` cycle.
- Asynchronous reset mid-frame: all outputs return to 0 immediately; after release, the block needs a fresh `do_it` arm.

## Structure
- Package `uart_pkg`:
  - FSM state typedef.
  - Baud divisor constants `BAUD_300` through `BAUD_921600` for a 100 MHz clock.
  - Default `CNT_W`/`BIT_W`.
- Sub-module `bit_cycle_cnt`: CNT_W-bit counter with `clr`/`en`/`target` inputs and a `hit` output. It is instantiated once, and the parent muxes `target` between `h_q` and `k_q`.
- Estimated size: around 150–250 lines of RTL in total.

## Test plan
- RUN mode, k=5, frame_bits=3, half_first=0, do_it held high:
  - `btu` is high in cycles 4, 9 and 14 after E0.
  - `frame_done` is high only in cycle 14.
  - `busy` falls after E15, and no further ticks occur while `do_it` stays high.
- HALF mode, k=10, frame_bits=2, half_first=1: `btu` is high at cycles 4, 14 and 24; `frame_done` is high at 24; `bit_idx` reads 0, 0, 1, 2 across the sequence.
- Clamps: k=0 behaves as k=2 (tick every 2 cycles); k=1 with HALF gives a half tick at cycle 0 (`h_q = 1`); frame_bits=0 ends the frame on the first tick.
- Abort: `do_it` dropped in RUN at `cnt = k_q - 1` gives no `btu` that cycle, and `cnt = 0`, `bit_idx = 0` next cycle. Re-arming with k=7 then gives the first tick at cycle 6.
- Input changes while armed: changing `k` from 5 to 9 mid-frame keeps ticks every 5 cycles until the frame ends. `reset` asserted mid-frame zeroes all outputs asynchronously, before the next clock edge.
- Width sweep: with CNT_W=24, BIT_W=5, k=2^24-1, frame_bits=31, all 31 ticks are spaced exactly 2^24-1 cycles apart with no counter overflow.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART datapath.
//   - bt_state_t    : state type of the bit-timing engine FSM
//   - BAUD_*        : clocks-per-bit divisors for a 100 MHz clock,
//                     rounded to the nearest integer
//   - DEFAULT_CNT_W : default width of the bit-time divisor/counter
//   - DEFAULT_BIT_W : default width of the frame length / bit index
package uart_pkg;

    localparam int DEFAULT_CNT_W = 20;
    localparam int DEFAULT_BIT_W = 4;

    localparam int unsigned BAUD_300    = 333333;
    localparam int unsigned BAUD_600    = 166667;
    localparam int unsigned BAUD_1200   = 83333;
    localparam int unsigned BAUD_2400   = 41667;
    localparam int unsigned BAUD_4800   = 20833;
    localparam int unsigned BAUD_9600   = 10417;
    localparam int unsigned BAUD_19200  = 5208;
    localparam int unsigned BAUD_38400  = 2604;
    localparam int unsigned BAUD_57600  = 1736;
    localparam int unsigned BAUD_115200 = 868;
    localparam int unsigned BAUD_230400 = 434;
    localparam int unsigned BAUD_460800 = 217;
    localparam int unsigned BAUD_921600 = 109;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HALF = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } bt_state_t;

endpackage

// File: rtl/bit_cycle_cnt.sv
// bit_cycle_cnt: free-running cycle counter with a programmable period.
// Ports:
//   clk    in  : rising-edge clock
//   reset  in  : asynchronous active-low reset
//   clr    in  : synchronous clear (wins over en)
//   en     in  : count enable
//   target in  : period in clocks; hit marks the last count of a period
//   hit    out : high while cnt == target - 1
// When enabled, the counter clears itself on the hit edge, so it never
// exceeds target - 1 and cannot wrap for any target <= 2^CNT_W - 1.
module bit_cycle_cnt
    import uart_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] target,
    output logic             hit
);

    logic [CNT_W-1:0] cnt;

    assign hit = (cnt == target - CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= hit ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bit_time_gen.sv
// bit_time_gen: bit-timing engine for the UART TX/RX shift FSMs.
// Emits a one-cycle btu pulse every k clocks while enabled, optionally
// preceded by a half-bit interval (receiver mid-bit sampling), and counts
// ticks per frame so the shift FSMs need no bit counters of their own.
// Ports:
//   clk        in  : rising-edge clock
//   reset      in  : asynchronous active-low reset
//   k          in  : clocks per bit (clamped to >= 2), sampled at arm
//   frame_bits in  : ticks per frame (0 treated as 1), sampled at arm
//   half_first in  : first interval is half a bit, sampled at arm
//   do_it      in  : level enable (see handshake note below)
//   btu        out : bit-time-up pulse, one cycle wide
//   bit_idx    out : ticks completed so far in the current frame
//   frame_done out : pulse coincident with the final btu of the frame
//   busy       out : high while timing a frame (HALF or RUN)
//
// Handshake: do_it is a level request. High while IDLE arms on the next
// edge; low in HALF/RUN aborts on the next edge and suppresses btu and
// frame_done combinationally in that same cycle. After a frame the block
// parks in DONE until do_it drops, so each frame needs a low cycle first.
module bit_time_gen
    import uart_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W,
    parameter int BIT_W = DEFAULT_BIT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] k,
    input  logic [BIT_W-1:0] frame_bits,
    input  logic             half_first,
    input  logic             do_it,
    output logic             btu,
    output logic [BIT_W-1:0] bit_idx,
    output logic             frame_done,
    output logic             busy
);

    bt_state_t        state;
    logic [CNT_W-1:0] k_q;
    logic [CNT_W-1:0] h_q;
    logic [BIT_W-1:0] nbits_q;

    logic [CNT_W-1:0] k_clamp;
    logic [CNT_W-1:0] h_clamp;
    logic [BIT_W-1:0] nbits_clamp;
    logic [CNT_W-1:0] target;
    logic             active;
    logic             cnt_clr;
    logic             hit;
    logic             last_bit;

    // Arm-time clamps: a period below 2 would leave no room for the half
    // interval, and a zero-length frame would never finish.
    assign k_clamp     = (k < CNT_W'(2)) ? CNT_W'(2) : k;
    assign h_clamp     = ((k_clamp >> 1) == '0) ? CNT_W'(1) : (k_clamp >> 1);
    assign nbits_clamp = (frame_bits == '0) ? BIT_W'(1) : frame_bits;

    assign active   = (state == ST_HALF) || (state == ST_RUN);
    // The counter is held at zero whenever it is not timing, and also on
    // the abort edge so a re-arm always starts from a clean count.
    assign cnt_clr  = !active || !do_it;
    assign target   = (state == ST_HALF) ? h_q : k_q;
    assign last_bit = (bit_idx == nbits_q - BIT_W'(1));

    assign btu        = do_it && active && hit;
    assign frame_done = do_it && (state == ST_RUN) && hit && last_bit;
    assign busy       = active;

    bit_cycle_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .en     (active),
        .target (target),
        .hit    (hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            k_q     <= '0;
            h_q     <= '0;
            nbits_q <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_idx <= '0;
                    if (do_it) begin
                        k_q     <= k_clamp;
                        h_q     <= h_clamp;
                        nbits_q <= nbits_clamp;
                        state   <= half_first ? ST_HALF : ST_RUN;
                    end
                end
                ST_HALF: begin
                    // The half tick only realigns sampling; it is not a bit.
                    if (!do_it) begin
                        state   <= ST_IDLE;
                        bit_idx <= '0;
                    end else if (hit) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!do_it) begin
                        state   <= ST_IDLE;
                        bit_idx <= '0;
                    end else if (hit) begin
                        bit_idx <= bit_idx + BIT_W'(1);
                        if (last_bit) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // bit_idx holds the frame length until do_it drops.
                    if (!do_it) begin
                        state   <= ST_IDLE;
                        bit_idx <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_time_gen.sv
module tb_bit_time_gen;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        reset;
    logic [19:0] k;
    logic [3:0]  frame_bits;
    logic        half_first;
    logic        do_it;
    logic        btu;
    logic [3:0]  bit_idx;
    logic        frame_done;
    logic        busy;

    // Narrow-counter instance used to hit the k = 2^CNT_W - 1 boundary.
    logic [7:0]  k_w;
    logic [4:0]  fb_w;
    logic        hf_w;
    logic        do_w;
    logic        btu_w;
    logic [4:0]  bidx_w;
    logic        fd_w;
    logic        busy_w;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit_time_gen #(.CNT_W(20), .BIT_W(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .k          (k),
        .frame_bits (frame_bits),
        .half_first (half_first),
        .do_it      (do_it),
        .btu        (btu),
        .bit_idx    (bit_idx),
        .frame_done (frame_done),
        .busy       (busy)
    );

    bit_time_gen #(.CNT_W(8), .BIT_W(5)) u_wide (
        .clk        (clk),
        .reset      (reset),
        .k          (k_w),
        .frame_bits (fb_w),
        .half_first (hf_w),
        .do_it      (do_w),
        .btu        (btu_w),
        .bit_idx    (bidx_w),
        .frame_done (fd_w),
        .busy       (busy_w)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: expected outputs in cycle c after the arm edge,
    // derived from tick positions (half tick at h-1, data tick j at
    // base + j*k - 1) rather than from any counter state.
    function automatic void model(input int kq, input int hq, input int n, input int hf,
                                  input int c, output bit e_btu, output bit e_fd,
                                  output bit e_busy, output int e_idx);
        int base;
        int last;
        int m;
        base   = hf ? hq : 0;
        last   = base + n * kq - 1;
        e_btu  = (hf != 0 && c == hq - 1) ||
                 (c >= base && c <= last && ((c - base + 1) % kq) == 0);
        e_fd   = (c == last);
        e_busy = (c <= last);
        m      = (c < base) ? 0 : (c - base) / kq;
        e_idx  = (m > n) ? n : m;
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs are driven 1 time unit after a rising edge, outputs sampled
    // 4 units after it (well clear of the next edge).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        do_it = 1'b0;
        repeat (n) step();
    endtask

    // Returns at the drive point of cycle 0 (just after E0).
    task automatic arm(input int kk, input int fb, input int hf);
        k          = 20'(kk);
        frame_bits = 4'(fb);
        half_first = 1'(hf);
        do_it      = 1'b1;
        step();
    endtask

    task automatic first_tick(input int limit, output int first);
        first = -1;
        for (int c = 0; c < limit; c++) begin
            #3;
            if (btu && first < 0) first = c;
            step();
        end
    endtask

    typedef struct {
        int k;
        int fb;
        int hf;
        int chg_at;   // cycle at which inputs are disturbed, -1 = never
        int k_new;
        int first;    // expected first btu cycle
        int done;     // expected frame_done cycle (also last busy cycle)
        int nticks;   // expected btu count including the half tick
        int nbits;    // expected final bit_idx
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input int idx, input vec_t v);
        int first;
        int done;
        int nb;
        int nd;
        int lastb;
        string tag;
        first = -1; done = -1; nb = 0; nd = 0; lastb = -1;
        tag = $sformatf("vec%0d", idx);
        idle(2);
        arm(v.k, v.fb, v.hf);
        for (int c = 0; c < v.done + 8; c++) begin
            if (c == v.chg_at) begin
                k          = 20'(v.k_new);
                frame_bits = ~frame_bits;
                half_first = ~half_first;
            end
            #3;
            if (btu) begin
                nb++;
                if (first < 0) first = c;
            end
            if (frame_done) begin
                nd++;
                done = c;
            end
            if (busy) lastb = c;
            step();
        end
        check({tag, "_first_btu"}, first, v.first);
        check({tag, "_done_cycle"}, done, v.done);
        check({tag, "_btu_count"}, nb, v.nticks);
        check({tag, "_done_count"}, nd, 1);
        check({tag, "_last_busy"}, lastb, v.done);
        check({tag, "_final_idx"}, 32'(bit_idx), v.nbits);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int f;
        reset = 1'b0; do_it = 1'b0; k = '0; frame_bits = '0; half_first = 1'b0;
        do_w = 1'b0; k_w = '0; fb_w = '0; hf_w = 1'b0;

        vecs[0] = '{5, 3, 0, -1, 0, 4, 14, 3, 3};
        vecs[1] = '{10, 2, 1, -1, 0, 4, 24, 3, 2};
        vecs[2] = '{0, 2, 0, -1, 0, 1, 3, 2, 2};
        vecs[3] = '{1, 1, 1, -1, 0, 0, 2, 2, 1};
        vecs[4] = '{4, 0, 0, -1, 0, 3, 3, 1, 1};
        vecs[5] = '{3, 0, 1, -1, 0, 0, 3, 2, 1};
        vecs[6] = '{2, 15, 0, -1, 0, 1, 29, 15, 15};
        vecs[7] = '{7, 1, 1, -1, 0, 2, 9, 2, 1};
        vecs[8] = '{5, 3, 0, 2, 9, 4, 14, 3, 3};
        vecs[9] = '{1, 2, 0, -1, 0, 1, 3, 2, 2};

        // Reset state
        #12;
        check("rst_btu", 32'(btu), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_bit_idx", 32'(bit_idx), 0);
        check("rst_wide_busy", 32'(busy_w), 0);
        step();
        reset = 1'b1;
        idle(2);

        // Table-driven frames
        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Abort in RUN exactly at the would-be tick, then re-arm with k=7
        idle(2);
        arm(5, 3, 0);
        repeat (8) step();
        #3;
        check("abort_pre_idx", 32'(bit_idx), 1);
        step();
        do_it = 1'b0;
        #3;
        check("abort_btu", 32'(btu), 0);
        check("abort_frame_done", 32'(frame_done), 0);
        step();
        #3;
        check("abort_busy", 32'(busy), 0);
        check("abort_idx", 32'(bit_idx), 0);
        arm(7, 2, 0);
        first_tick(12, f);
        check("rearm_first_btu", f, 6);

        // Asynchronous reset mid-frame, while btu is high
        idle(2);
        arm(5, 3, 0);
        repeat (9) step();
        #3;
        check("prereset_btu", 32'(btu), 1);
        check("prereset_idx", 32'(bit_idx), 1);
        reset = 1'b0;
        do_it = 1'b0;
        #1;
        check("async_rst_btu", 32'(btu), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_idx", 32'(bit_idx), 0);
        check("async_rst_frame_done", 32'(frame_done), 0);
        step();
        reset = 1'b1;
        idle(3);
        check("post_rst_busy", 32'(busy), 0);
        arm(4, 1, 0);
        first_tick(10, f);
        check("post_rst_first_btu", f, 3);

        // Randomised frames with inputs scrambled while armed, some aborted
        for (int it = 0; it < 25; it++) begin
            int kk, fb, hf, kq, hq, n, base, last, abort_at;
            bit e_btu, e_fd, e_busy;
            int e_idx;
            kk = $urandom_range(0, 12);
            fb = $urandom_range(0, 15);
            hf = $urandom_range(0, 1);
            kq = (kk < 2) ? 2 : kk;
            hq = kq / 2;
            n  = (fb == 0) ? 1 : fb;
            base = hf ? hq : 0;
            last = base + n * kq - 1;
            abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, last) : -1;
            idle($urandom_range(1, 3));
            arm(kk, fb, hf);
            for (int c = 0; c <= last + 4; c++) begin
                k          = 20'($urandom);
                frame_bits = 4'($urandom);
                half_first = 1'($urandom);
                if (c == abort_at) do_it = 1'b0;
                #3;
                model(kq, hq, n, hf, c, e_btu, e_fd, e_busy, e_idx);
                if (abort_at >= 0 && c == abort_at) begin
                    e_btu = 1'b0;
                    e_fd  = 1'b0;
                end else if (abort_at >= 0 && c > abort_at) begin
                    e_btu = 1'b0; e_fd = 1'b0; e_busy = 1'b0; e_idx = 0;
                end
                check($sformatf("rnd%0d_c%0d_btu", it, c), 32'(btu), 32'(e_btu));
                check($sformatf("rnd%0d_c%0d_fd", it, c), 32'(frame_done), 32'(e_fd));
                check($sformatf("rnd%0d_c%0d_busy", it, c), 32'(busy), 32'(e_busy));
                check($sformatf("rnd%0d_c%0d_idx", it, c), 32'(bit_idx), e_idx);
                step();
                if (abort_at >= 0 && c == abort_at + 2) break;
            end
        end
        idle(2);

        // Width boundary: k = 2^8 - 1 on an 8-bit counter, 31-bit frame
        begin
            int prev, nt, done;
            prev = -1; nt = 0; done = -1;
            k_w = 8'd255; fb_w = 5'd31; hf_w = 1'b0; do_w = 1'b1;
            step();
            for (int c = 0; c < 7912; c++) begin
                #3;
                if (btu_w) begin
                    if (prev < 0) check("wide_first_btu", c, 254);
                    else check($sformatf("wide_spacing%0d", nt), c - prev, 255);
                    prev = c;
                    nt++;
                end
                if (fd_w) done = c;
                step();
            end
            check("wide_btu_count", nt, 31);
            check("wide_done_cycle", done, 7904);
            check("wide_final_idx", 32'(bidx_w), 31);
            check("wide_busy_end", 32'(busy_w), 0);
            do_w = 1'b0;
        end

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
